// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game core: mole placement, per-mole lifetime timer, hit/miss scoring with
// optional penalty, and a lives counter with game-over. All outputs are registered.
module mole_game_ctrl #(
   parameter int unsigned NUM_HOLES  = 8,
   parameter int unsigned POS_W      = 3,
   parameter int unsigned SCORE_W    = 8,
   parameter int unsigned MOLE_TICKS = 12,
   parameter int unsigned GAP_TICKS  = 2,
   parameter int unsigned LIVES      = 3,
   parameter bit          PENALTY_EN = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic               i_start,
   input  logic               i_guess_now,
   input  logic [POS_W-1:0]   i_guess_pos,
   input  logic [POS_W-1:0]   i_rand_val,
   input  logic               i_force_en,
   input  logic [POS_W-1:0]   i_force_pos,
   output logic [POS_W-1:0]   o_mole_pos,
   output logic               o_mole_up,
   output logic [SCORE_W-1:0] o_score,
   output logic [3:0]         o_lives,
   output logic               o_hit,
   output logic               o_miss,
   output logic               o_game_over
);

   localparam int unsigned TMAX    = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int unsigned TIMER_W = $clog2(TMAX + 1);

   localparam logic [TIMER_W-1:0] MOLE_T     = TIMER_W'(MOLE_TICKS);
   localparam logic [TIMER_W-1:0] GAP_T      = TIMER_W'(GAP_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(NUM_HOLES - 1);
   localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   typedef enum logic [2:0] {StIdle, StSpawn, StUp, StCool, StOver} state_e;

   state_e             r_state;
   logic [TIMER_W-1:0] r_timer;
   logic [POS_W-1:0]   r_mole_pos;
   logic               r_mole_up;
   logic [SCORE_W-1:0] r_score;
   logic [3:0]         r_lives;
   logic               r_hit;
   logic               r_miss;
   logic               r_game_over;

   logic [POS_W-1:0]   w_rand_mod;
   logic [POS_W-1:0]   w_spawn_pos;
   logic               w_correct;
   logic               w_wrong;
   logic               w_expire;

   // Random spawns never repeat the previous hole; forced spawns are clamped into range.
   always_comb begin
      w_rand_mod = POS_W'(32'(i_rand_val) % NUM_HOLES);
      if (i_force_en) begin
         w_spawn_pos = (32'(i_force_pos) >= NUM_HOLES) ? LAST_POS : i_force_pos;
      end else if (w_rand_mod == r_mole_pos) begin
         w_spawn_pos = (w_rand_mod == LAST_POS) ? '0 : w_rand_mod + POS_W'(1);
      end else begin
         w_spawn_pos = w_rand_mod;
      end
   end

   assign w_correct = i_guess_now && (i_guess_pos == r_mole_pos);
   assign w_wrong   = i_guess_now && !w_correct;
   assign w_expire  = i_tick && (r_timer == TIMER_ONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_timer     <= '0;
         r_mole_pos  <= '0;
         r_mole_up   <= 1'b0;
         r_score     <= '0;
         r_lives     <= LIVES_INIT;
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         if (i_start) begin
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_mole_up   <= 1'b0;
            r_game_over <= 1'b0;
            r_state     <= StSpawn;
         end else begin
            case (r_state)
               StIdle: ;
               StSpawn: begin
                  r_mole_pos <= w_spawn_pos;
                  r_timer    <= MOLE_T;
                  r_mole_up  <= 1'b1;
                  r_state    <= StUp;
               end
               StUp: begin
                  // A correct guess wins over a same-cycle expiry tick.
                  if (w_correct) begin
                     r_hit     <= 1'b1;
                     r_mole_up <= 1'b0;
                     r_timer   <= GAP_T;
                     r_state   <= StCool;
                     if (r_score != SCORE_MAX) r_score <= r_score + SCORE_W'(1);
                  end else begin
                     if (w_wrong) begin
                        r_miss <= 1'b1;
                        if (PENALTY_EN && (r_score != '0)) r_score <= r_score - SCORE_W'(1);
                     end
                     if (i_tick) begin
                        r_timer <= r_timer - TIMER_ONE;
                        if (w_expire) begin
                           r_miss    <= 1'b1;
                           r_mole_up <= 1'b0;
                           if (r_lives != 4'd0) r_lives <= r_lives - 4'd1;
                           if (r_lives < 4'd2) begin
                              r_game_over <= 1'b1;
                              r_state     <= StOver;
                           end else begin
                              r_timer <= GAP_T;
                              r_state <= StCool;
                           end
                        end
                     end
                  end
               end
               StCool: begin
                  if (i_tick) begin
                     r_timer <= r_timer - TIMER_ONE;
                     if (r_timer == TIMER_ONE) r_state <= StSpawn;
                  end
               end
               StOver: ;
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_mole_pos  = r_mole_pos;
   assign o_mole_up   = r_mole_up;
   assign o_score     = r_score;
   assign o_lives     = r_lives;
   assign o_hit       = r_hit;
   assign o_miss      = r_miss;
   assign o_game_over = r_game_over;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: default instance plus a NUM_HOLES=6, SCORE_W=4 instance
// sharing stimulus; whichever instance is not under test is held in reset.
module tb_mole_game_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       b_rst = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       guess_now = 1'b0;
   logic [2:0] guess_pos = '0;
   logic [2:0] rand_val = '0;
   logic       force_en = 1'b0;
   logic [2:0] force_pos = '0;

   logic [2:0] mole_pos;
   logic       mole_up;
   logic [7:0] score;
   logic [3:0] lives;
   logic       hit;
   logic       miss;
   logic       game_over;

   logic [2:0] b_mole_pos;
   logic       b_mole_up;
   logic [3:0] b_score;
   logic [3:0] b_lives;
   logic       b_hit;
   logic       b_miss;
   logic       b_game_over;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mole_game_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start),
      .i_guess_now(guess_now), .i_guess_pos(guess_pos), .i_rand_val(rand_val),
      .i_force_en(force_en), .i_force_pos(force_pos),
      .o_mole_pos(mole_pos), .o_mole_up(mole_up), .o_score(score), .o_lives(lives),
      .o_hit(hit), .o_miss(miss), .o_game_over(game_over)
   );

   mole_game_ctrl #(.NUM_HOLES(6), .SCORE_W(4)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_tick(tick), .i_start(start),
      .i_guess_now(guess_now), .i_guess_pos(guess_pos), .i_rand_val(rand_val),
      .i_force_en(force_en), .i_force_pos(force_pos),
      .o_mole_pos(b_mole_pos), .o_mole_up(b_mole_up), .o_score(b_score), .o_lives(b_lives),
      .o_hit(b_hit), .o_miss(b_miss), .o_game_over(b_game_over)
   );

   // Observed state: {game_over, hit, miss, mole_up, lives, mole_pos, score}
   logic [18:0] s1;
   logic [14:0] s2;
   assign s1 = {game_over, hit, miss, mole_up, lives, mole_pos, score};
   assign s2 = {b_game_over, b_hit, b_miss, b_mole_up, b_lives, b_mole_pos, b_score};

   function automatic logic [18:0] st(input logic go, h, m, up, input logic [3:0] lv,
                                      input logic [2:0] pos, input logic [7:0] sc);
      return {go, h, m, up, lv, pos, sc};
   endfunction

   function automatic logic [14:0] st2(input logic go, h, m, up, input logic [3:0] lv,
                                       input logic [2:0] pos, input logic [3:0] sc);
      return {go, h, m, up, lv, pos, sc};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
      end
   endtask

   task automatic guess(input logic [2:0] p);
      guess_now = 1'b1;
      guess_pos = p;
      cyc();
      guess_now = 1'b0;
   endtask

   task automatic test_reset();
      logic [18:0] e;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      e = st(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL reset: got %b want %b", s1, e); end
      ticks(1);
      e = st(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL idle_hold: got %b want %b", s1, e); end
   endtask

   task automatic test_basic_hit();
      logic [18:0] e;
      force_en = 1'b1;
      force_pos = 3'd5;
      start = 1'b1;
      cyc();
      start = 1'b0;
      e = st(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL spawn_cycle: got %b want %b", s1, e); end
      cyc();
      e = st(0, 0, 0, 1, 3, 5, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL mole_up: got %b want %b", s1, e); end
      guess(3'd5);
      e = st(0, 1, 0, 0, 3, 5, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL hit_pulse: got %b want %b", s1, e); end
      cyc();
      e = st(0, 0, 0, 0, 3, 5, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL hit_one_cycle: got %b want %b", s1, e); end
      ticks(1);
      e = st(0, 0, 0, 0, 3, 5, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL gap_tick1: got %b want %b", s1, e); end
      ticks(1);
      cyc();
      e = st(0, 0, 0, 1, 3, 5, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL respawn: got %b want %b", s1, e); end
   endtask

   task automatic test_penalty();
      logic [18:0] e;
      for (int i = 0; i < 3; i++) begin
         guess(3'd2);
         e = st(0, 0, 1, 1, 3, 5, 0); n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL penalty_%0d: got %b want %b", i, s1, e); end
         cyc();
         e = st(0, 0, 0, 1, 3, 5, 0); n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL miss_clr_%0d: got %b want %b", i, s1, e); end
      end
   endtask

   task automatic test_timeout();
      logic [18:0] e;
      logic [3:0]  lv;
      for (int m = 1; m <= 3; m++) begin
         lv = 4'(4 - m);
         ticks(11);
         e = st(0, 0, 0, 1, lv, 5, 0); n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL pre_expire_%0d: got %b want %b", m, s1, e); end
         ticks(1);
         if (m < 3) e = st(0, 0, 1, 0, lv - 4'd1, 5, 0);
         else       e = st(1, 0, 1, 0, 0, 5, 0);
         n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL expire_%0d: got %b want %b", m, s1, e); end
         if (m < 3) begin
            ticks(2);
            cyc();
         end
      end
      guess_now = 1'b1;
      guess_pos = 3'd5;
      tick = 1'b1;
      cyc();
      guess_now = 1'b0;
      tick = 1'b0;
      e = st(1, 0, 0, 0, 0, 5, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL over_ignore: got %b want %b", s1, e); end
   endtask

   task automatic test_race();
      logic [18:0] e;
      start = 1'b1;
      cyc();
      start = 1'b0;
      e = st(0, 0, 0, 0, 3, 5, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL over_restart: got %b want %b", s1, e); end
      cyc();
      ticks(11);
      tick = 1'b1;
      guess(3'd5);
      tick = 1'b0;
      e = st(0, 1, 0, 0, 3, 5, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL race_hit: got %b want %b", s1, e); end
      ticks(2);
      cyc();
      ticks(11);
      tick = 1'b1;
      guess(3'd2);
      tick = 1'b0;
      e = st(0, 0, 1, 0, 2, 5, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL race_wrong: got %b want %b", s1, e); end
      cyc();
      e = st(0, 0, 0, 0, 2, 5, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL race_single: got %b want %b", s1, e); end
   endtask

   task automatic test_spawn_rules();
      logic [18:0] e;
      logic [2:0]  pos [4] = '{3'd3, 3'd4, 3'd3, 3'd4};
      force_en = 1'b0;
      rand_val = 3'd3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         e = st(0, 0, 0, 1, 3, pos[k], 8'(k)); n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL spawn_pos_%0d: got %b want %b", k, s1, e); end
         guess(pos[k]);
         e = st(0, 1, 0, 0, 3, pos[k], 8'(k + 1)); n_vec++;
         if (s1 !== e) begin n_bad++; $display("FAIL spawn_hit_%0d: got %b want %b", k, s1, e); end
         if (k < 3) ticks(2);
      end
   endtask

   task automatic test_restart();
      logic [18:0] e;
      start = 1'b1;
      cyc();
      start = 1'b0;
      e = st(0, 0, 0, 0, 3, 4, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL cool_restart: got %b want %b", s1, e); end
      cyc();
      e = st(0, 0, 0, 1, 3, 3, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL restart_up: got %b want %b", s1, e); end
      start = 1'b1;
      guess(3'd3);
      start = 1'b0;
      e = st(0, 0, 0, 0, 3, 3, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL up_restart: got %b want %b", s1, e); end
      cyc();
      e = st(0, 0, 0, 1, 3, 4, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL up_restart_pos: got %b want %b", s1, e); end
   endtask

   task automatic test_reset_midgame();
      logic [18:0] e;
      guess(3'd4);
      ticks(2);
      cyc();
      ticks(12);
      e = st(0, 0, 1, 0, 2, 3, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL mid_expire: got %b want %b", s1, e); end
      ticks(2);
      cyc();
      e = st(0, 0, 0, 1, 2, 4, 1); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL mid_up: got %b want %b", s1, e); end
      rst = 1'b1;
      guess(3'd4);
      rst = 1'b0;
      e = st(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL mid_reset: got %b want %b", s1, e); end
      ticks(1);
      e = st(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s1 !== e) begin n_bad++; $display("FAIL post_reset_idle: got %b want %b", s1, e); end
   endtask

   task automatic test_small_variant();
      logic [14:0] e;
      logic [3:0]  sc;
      rst = 1'b1;
      b_rst = 1'b1;
      cyc();
      b_rst = 1'b0;
      e = st2(0, 0, 0, 0, 3, 0, 0); n_vec++;
      if (s2 !== e) begin n_bad++; $display("FAIL b_reset: got %b want %b", s2, e); end
      force_en = 1'b1;
      force_pos = 3'd7;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cyc();
         e = st2(0, 0, 0, 1, 3, 5, 4'(k)); n_vec++;
         if (s2 !== e) begin n_bad++; $display("FAIL b_clamp_%0d: got %b want %b", k, s2, e); end
         guess(3'd5);
         sc = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
         e = st2(0, 1, 0, 0, 3, 5, sc); n_vec++;
         if (s2 !== e) begin n_bad++; $display("FAIL b_sat_%0d: got %b want %b", k, s2, e); end
         ticks(2);
      end
      force_en = 1'b0;
      rand_val = 3'd7;
      cyc();
      e = st2(0, 0, 0, 1, 3, 1, 15); n_vec++;
      if (s2 !== e) begin n_bad++; $display("FAIL b_rand_mod: got %b want %b", s2, e); end
      guess(3'd1);
      rand_val = 3'd5;
      ticks(2);
      cyc();
      e = st2(0, 0, 0, 1, 3, 5, 15); n_vec++;
      if (s2 !== e) begin n_bad++; $display("FAIL b_rand_5: got %b want %b", s2, e); end
      guess(3'd5);
      ticks(2);
      cyc();
      e = st2(0, 0, 0, 1, 3, 0, 15); n_vec++;
      if (s2 !== e) begin n_bad++; $display("FAIL b_wrap: got %b want %b", s2, e); end
      guess(3'd6);
      e = st2(0, 0, 1, 1, 3, 0, 14); n_vec++;
      if (s2 !== e) begin n_bad++; $display("FAIL b_out_of_range: got %b want %b", s2, e); end
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_penalty();
      test_timeout();
      test_race();
      test_spawn_rules();
      test_restart();
      test_reset_midgame();
      test_small_variant();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Parametrised successor to the whack-a-mole game core: one block handles mole placement, a per-mole lifetime timer, hit/miss scoring with optional penalty, and a lives counter with game-over.
- Sits between user_input (guess strobe and position), an external LFSR (random value) and the display logic.
- Generalises hole count, score width, mole lifetime, gap time and lives.
- Adds timed moles, penalties, lives and game-over, which the previous single-position scorer did not have.

Parameters:
- NUM_HOLES, 8, number of mole positions (2..16).
- POS_W, 3, width of position fields; must satisfy 2^POS_W >= NUM_HOLES.
- SCORE_W, 8, score width.
- MOLE_TICKS, 12, number of ticks a mole stays up (>=1).
- GAP_TICKS, 2, number of ticks with no mole between moles (>=1).
- LIVES, 3, starting lives (1..15).
- PENALTY_EN, 1, when 1 a wrong guess decrements score.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle game-time pulse from the clock divider.
- start  in  1  one-cycle pulse; starts or restarts a game.
- guess_now  in  1  one-cycle strobe; guess_pos is valid this cycle.
- guess_pos  in  POS_W  hole the user selected.
- rand_val  in  POS_W  free-running random value.
- force_en  in  1  when high, use force_pos as the spawn position (test/debug).
- force_pos  in  POS_W  forced mole position.
- mole_pos  out  POS_W  current mole hole.
- mole_up  out  1  mole is visible.
- score  out  SCORE_W  current score.
- lives  out  4  remaining lives.
- hit  out  1  one-cycle pulse on a correct guess.
- miss  out  1  one-cycle pulse on a wrong guess or a timeout.
- game_over  out  1  high while in the OVER state.

Behaviour:
- Reset, applied on the clk edge while rst=1:
  - state=IDLE, mole_pos=0, mole_up=0, score=0, lives=LIVES, hit=0, miss=0, game_over=0, timer=0.
  - Reset mid-game aborts immediately; there is no partial-state carryover.
- All outputs are registered. hit and miss assert the cycle after the causing input and last exactly one cycle.
- States:
  - IDLE: mole_up=0. On start: score<=0, lives<=LIVES, go to SPAWN.
  - SPAWN (exactly 1 cycle):
    - Candidate position p = force_en ? force_pos : (rand_val mod NUM_HOLES).
    - If force_en=0 and p equals the previous mole_pos, use p+1, wrapping to 0 at NUM_HOLES.
    - If force_en=1 and force_pos >= NUM_HOLES, use NUM_HOLES-1.
    - Load mole_pos and timer=MOLE_TICKS, set mole_up=1, go to UP.
  - UP, evaluated in priority order each cycle:
    1. guess_now with guess_pos==mole_pos: hit; score += 1, saturating at 2^SCORE_W-1; mole_up<=0; timer=GAP_TICKS; go to COOLDOWN.
    2. guess_now with guess_pos!=mole_pos (this includes guess_pos >= NUM_HOLES): miss; if PENALTY_EN, score -= 1, saturating at 0; stay in UP. The timer keeps counting if tick is also high.
    3. tick: timer -= 1. If timer was 1 (expiry): miss; lives -= 1; mole_up<=0. If the new lives==0, go to OVER; otherwise timer=GAP_TICKS and go to COOLDOWN.
  - Simultaneous events in UP:
    - A correct guess in the same cycle as the expiry tick counts as a hit only; no life is lost.
    - A wrong guess in the same cycle as the expiry tick produces a single miss pulse, applies the score penalty and the life loss together, then follows the expiry transition.
  - COOLDOWN: guesses are ignored (no hit/miss). On each tick, timer -= 1; when timer reaches 0, go to SPAWN.
  - OVER: game_over=1, mole_up=0, score and mole_pos frozen, guesses ignored. On start, behave as IDLE+start.
- start in UP or COOLDOWN restarts the game: score=0, lives=LIVES, go to SPAWN. Neither hit nor miss pulses that cycle.
- lives never underflows. score never wraps in either direction.

Test Plan:
- Basic hit: rst, start, force_en=1, force_pos=5; guess_now with guess_pos=5 one cycle after mole_up rises -> hit pulses 1 cycle, score=1, mole_up=0; SPAWN occurs after GAP_TICKS=2 ticks.
- Penalty and saturation: score=1, then three wrong guesses (guess_pos=2, mole_pos=5) -> three miss pulses, score 0,0,0, still in UP; separately, with SCORE_W=4 and 16 hits -> score holds at 15.
- Timeout and lives: no guesses, 12 ticks per mole, LIVES=3 -> three miss pulses, lives 2,1,0; game_over=1 after the third expiry; a subsequent guess_now produces no pulse.
- Same-cycle race: a correct guess and the expiry tick in one cycle -> hit=1, miss=0, lives unchanged, score+1.
- Spawn rules: force_en=0, rand_val=3 held constant -> consecutive mole_pos values 3,4,3,4; force_pos=7 with NUM_HOLES=6 -> mole_pos=5.
- Reset and restart mid-game: rst during UP -> all outputs return to reset values the next cycle; start during COOLDOWN -> score=0, lives=3, mole_up=1 two cycles later.
